dmem_block_responder: RTL and testbench

- Memory-side responder for the pipelined MIPS data-cache interface.
- Services 256-bit line reads and writes (dBlkRead/dBlkWrite) and 32-bit word reads and writes (MemRead/MemWrite) issued by the core.
- Applies a programmable access latency and reports completion with a one-cycle done pulse.
- Sits between the core's MEM stage/D-cache and the backing store; the core holds FREEZE while mem_busy is high.

---
 rtl/dmem_pkg.sv | 37 +++
 rtl/dmem_line_array.sv | 35 +++
 rtl/dmem_block_responder.sv | 159 +++++++++++++++
 tb/tb_dmem_block_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory block responder.
package dmem_pkg;

    localparam int LINE_W         = 256;
    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 8;
    localparam int OFFSET_LSB     = 2;
    localparam int LINE_LSB       = 5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    typedef enum logic [2:0] {
        REQ_NONE,
        REQ_BLK_WR,
        REQ_BLK_RD,
        REQ_WORD_WR,
        REQ_WORD_RD
    } dmem_req_t;

    function automatic dmem_req_t dmem_pick(
        input logic blk_wr,
        input logic blk_rd,
        input logic word_wr,
        input logic word_rd
    );
        if (blk_wr)       return REQ_BLK_WR;
        else if (blk_rd)  return REQ_BLK_RD;
        else if (word_wr) return REQ_WORD_WR;
        else if (word_rd) return REQ_WORD_RD;
        else              return REQ_NONE;
    endfunction

endpackage

// File: rtl/dmem_line_array.sv
// Single-port line store: per-word write enables, registered read port.
module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int LINE_COUNT = 256,
    parameter int AW         = $clog2(LINE_COUNT)
) (
    input  logic                      clk_i,
    input  logic [AW-1:0]             addr_i,
    input  logic                      we_i,
    input  logic [WORDS_PER_LINE-1:0] wmask_i,
    input  logic [LINE_W-1:0]         wdata_i,
    input  logic                      re_i,
    output logic [LINE_W-1:0]         rdata_o
);

    logic [LINE_W-1:0] mem_q [LINE_COUNT];
    logic [LINE_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int w = 0; w < WORDS_PER_LINE; w++) begin
                if (wmask_i[w]) begin
                    mem_q[addr_i][w*WORD_W +: WORD_W] <= wdata_i[w*WORD_W +: WORD_W];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_block_responder.sv
// Latency-programmable line/word memory responder for the D-cache port.
// Optional protocol checker: define DMEM_PROTO_CHECK_EN.
module dmem_block_responder
    import dmem_pkg::*;
#(
    parameter int LINE_COUNT = 256,
    parameter int LATENCY    = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       data_address_2DM,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              dBlkRead,
    input  logic              dBlkWrite,
    input  logic [WORD_W-1:0] data_write_2DM,
    input  logic [LINE_W-1:0] block_write_2DM,
    output logic [WORD_W-1:0] data_read_fDM,
    output logic [LINE_W-1:0] block_read_fDM,
    output logic              mem_busy,
    output logic              blk_done,
    output logic              proto_err
);

    localparam int AW = $clog2(LINE_COUNT);

    dmem_state_t               state_q;
    dmem_req_t                 req_q;
    logic [3:0]                cnt_q;
    logic [AW-1:0]             line_q;
    logic [2:0]                off_q;
    logic [LINE_W-1:0]         wdata_q;
    logic [WORDS_PER_LINE-1:0] wmask_q;
    logic                      busy_q;
    logic                      done_q;
    logic [WORD_W-1:0]         data_rd_q;
    logic [LINE_W-1:0]         blk_rd_q;

    dmem_req_t                 req_d;
    logic [AW-1:0]             line_d;
    logic [2:0]                off_d;
    logic [LINE_W-1:0]         wdata_d;
    logic [WORDS_PER_LINE-1:0] wmask_d;

    logic                      commit;
    logic                      is_wr;
    logic [AW-1:0]             arr_addr;
    logic [LINE_W-1:0]         arr_rdata;
    logic                      unused_addr_bits;

    assign req_d  = dmem_pick(dBlkWrite, dBlkRead, MemWrite, MemRead);
    assign line_d = data_address_2DM[LINE_LSB +: AW];
    assign off_d  = data_address_2DM[OFFSET_LSB +: 3];

    // Word writes replicate the word to every lane; the mask picks one.
    assign wdata_d = (req_d == REQ_BLK_WR) ? block_write_2DM
                                           : {WORDS_PER_LINE{data_write_2DM}};
    assign wmask_d = (req_d == REQ_BLK_WR) ? '1
                                           : WORDS_PER_LINE'(1) << off_d;

    assign unused_addr_bits = ^{data_address_2DM[31:LINE_LSB+AW],
                                data_address_2DM[1:0]};

    assign commit = (state_q == WAIT) && (cnt_q == 4'd0);
    assign is_wr  = (req_q == REQ_BLK_WR) || (req_q == REQ_WORD_WR);

    // Array is read every cycle before commit so the line is ready on the commit edge.
    assign arr_addr = (state_q == IDLE) ? line_d : line_q;

    dmem_line_array #(
        .LINE_COUNT(LINE_COUNT),
        .AW        (AW)
    ) u_array (
        .clk_i  (CLK),
        .addr_i (arr_addr),
        .we_i   (commit && is_wr),
        .wmask_i(wmask_q),
        .wdata_i(wdata_q),
        .re_i   (state_q != RESP),
        .rdata_o(arr_rdata)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            req_q     <= REQ_NONE;
            cnt_q     <= '0;
            line_q    <= '0;
            off_q     <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            data_rd_q <= '0;
            blk_rd_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_d != REQ_NONE) begin
                        req_q   <= req_d;
                        line_q  <= line_d;
                        off_q   <= off_d;
                        wdata_q <= wdata_d;
                        wmask_q <= wmask_d;
                        cnt_q   <= 4'(LATENCY - 1);
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        done_q  <= 1'b1;
                        state_q <= RESP;
                        if (req_q == REQ_BLK_RD || req_q == REQ_WORD_RD) begin
                            blk_rd_q <= arr_rdata;
                        end
                        if (req_q == REQ_WORD_RD) begin
                            data_rd_q <= arr_rdata[{off_q, 5'b0} +: WORD_W];
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_read_fDM  = data_rd_q;
    assign block_read_fDM = blk_rd_q;
    assign mem_busy       = busy_q;
    assign blk_done       = done_q;

`ifdef DMEM_PROTO_CHECK_EN
    logic [3:0] reqs;
    logic       perr_q;

    assign reqs = {dBlkWrite, dBlkRead, MemWrite, MemRead};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            perr_q <= 1'b0;
        end else if (((state_q == IDLE) && ((reqs & (reqs - 4'd1)) != 4'd0)) ||
                     ((state_q == WAIT) && (reqs != 4'd0))) begin
            perr_q <= 1'b1;
        end
    end

    assign proto_err = perr_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_block_responder.sv
// Randomised scoreboard bench for dmem_block_responder.
module tb_dmem_block_responder;

    localparam int L  = 4;
    localparam int LC = 256;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  addr = '0;
    logic         mrd = 1'b0, mwr = 1'b0, brd = 1'b0, bwr = 1'b0;
    logic [31:0]  wd = '0;
    logic [255:0] wb = '0;
    logic [31:0]  drd;
    logic [255:0] brd_o;
    logic         busy, done, perr;

    dmem_block_responder #(.LINE_COUNT(LC), .LATENCY(L)) dut (
        .CLK             (clk),
        .RESET           (rst),
        .data_address_2DM(addr),
        .MemRead         (mrd),
        .MemWrite        (mwr),
        .dBlkRead        (brd),
        .dBlkWrite       (bwr),
        .data_write_2DM  (wd),
        .block_write_2DM (wb),
        .data_read_fDM   (drd),
        .block_read_fDM  (brd_o),
        .mem_busy        (busy),
        .blk_done        (done),
        .proto_err       (perr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           due;
        logic [255:0] blk;
        logic [31:0]  word;
    } exp_t;

    exp_t         sb[$];
    logic [255:0] mem_m [LC];
    logic [255:0] last_blk = '0;
    logic [31:0]  last_word = '0;
    bit           exp_perr = 0;
    int           checks = 0;
    int           errors = 0;

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop one expectation per completion pulse.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", 256'(cyc), 256'(e.due));
                check("block_read", brd_o, e.blk);
                check("word_read", 256'(drd), 256'(e.word));
                check("busy_at_done", 256'(busy), 256'(1));
            end
        end else if (sb.size() != 0 && cyc > sb[0].due) begin
            check("done_timeout", 256'(cyc), 256'(sb[0].due));
            void'(sb.pop_front());
        end
    end

    task automatic clear_reqs();
        mrd = 0; mwr = 0; brd = 0; bwr = 0;
    endtask

    // Issue one transaction at a negedge and update the reference model.
    task automatic issue(input bit b_wr, input bit b_rd, input bit w_wr,
                         input bit w_rd, input logic [31:0] a,
                         input logic [31:0] d, input logic [255:0] blk,
                         input bit inject);
        int ln, o;
        exp_t e;
        ln = int'(a[12:5]) % LC;
        o  = int'(a[4:2]);
        if (b_wr)      mem_m[ln] = blk;
        else if (b_rd) last_blk = mem_m[ln];
        else if (w_wr) mem_m[ln][o*32 +: 32] = d;
        else if (w_rd) begin
            last_blk  = mem_m[ln];
            last_word = mem_m[ln][o*32 +: 32];
        end
`ifdef DMEM_PROTO_CHECK_EN
        if (int'(b_wr) + int'(b_rd) + int'(w_wr) + int'(w_rd) > 1) exp_perr = 1;
        if (inject) exp_perr = 1;
`endif
        e.due  = cyc + 1 + L;
        e.blk  = last_blk;
        e.word = last_word;
        sb.push_back(e);
        addr = a; wd = d; wb = blk;
        bwr = b_wr; brd = b_rd; mwr = w_wr; mrd = w_rd;
        @(negedge clk);
        clear_reqs();
        if (inject) brd = 1;
        @(negedge clk);
        clear_reqs();
        repeat (L) @(negedge clk);
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    logic [255:0] pat;
    logic [255:0] old2;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_data_read", 256'(drd), 256'(0));
        check("rst_block_read", brd_o, '0);
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_perr", 256'(perr), 256'(0));
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            issue(1, 0, 0, 0, 32'(i << 5), '0, rand_line(), 0);

        for (int i = 0; i < 8; i++) pat[i*32 +: 32] = 32'(i);
        issue(1, 0, 0, 0, 32'h40, '0, pat, 0);
        issue(0, 1, 0, 0, 32'h40, '0, '0, 0);
        issue(0, 0, 1, 0, 32'h4C, 32'hDEADBEEF, '0, 0);
        issue(0, 1, 0, 0, 32'h40, '0, '0, 0);
        issue(0, 0, 0, 1, 32'h4C, '0, '0, 0);
        check("word3_model", 256'(last_word), 256'(32'hDEADBEEF));
        issue(0, 1, 0, 0, 32'h2040, '0, '0, 0);
        issue(0, 1, 0, 0, 32'h20, '0, '0, 1);
        check("perr_after_wait_req", 256'(perr), 256'(exp_perr));
        issue(1, 0, 0, 1, 32'h60, '0, rand_line(), 0);
        check("perr_after_multi", 256'(perr), 256'(exp_perr));
        issue(0, 0, 0, 1, 32'h64, '0, '0, 0);

        // Abort a line write two cycles in; the old line must survive.
        old2 = mem_m[2];
        addr = 32'h40; wb = rand_line(); bwr = 1;
        @(negedge clk);
        clear_reqs();
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("abort_busy", 256'(busy), 256'(0));
        check("abort_done", 256'(done), 256'(0));
        check("abort_perr", 256'(perr), 256'(0));
        repeat (3) @(negedge clk);
        rst = 0;
        last_blk = '0; last_word = '0; exp_perr = 0;
        @(negedge clk);
        check("abort_busy_idle", 256'(busy), 256'(0));
        issue(0, 1, 0, 0, 32'h40, '0, '0, 0);
        check("abort_model_line", last_blk, old2);

        for (int n = 0; n < 40; n++) begin
            int k;
            logic [31:0] a;
            k = $urandom_range(0, 3);
            a = ($urandom & 32'hFFFF_E003) | 32'($urandom_range(0, 7) << 5)
                | 32'($urandom_range(0, 7) << 2);
            issue(k == 0, k == 1, k == 2, k == 3, a, $urandom, rand_line(), 0);
        end

        repeat (L + 4) @(negedge clk);
        check("sb_drained", 256'(sb.size()), 256'(0));
        check("final_perr", 256'(perr), 256'(exp_perr));
        check("final_busy", 256'(busy), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
